// File: rtl/picorv32_arb_pkg.sv
// Shared types and helpers for the picorv32 native-port arbiter.
package picorv32_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN} arb_state_t;

    localparam int MAX_PORTS = 8;
    localparam int PTR_W     = $clog2(MAX_PORTS);

    function automatic logic [PTR_W-1:0] rr_next(input logic [PTR_W-1:0] ptr, input int unsigned n);
        if (32'(ptr) + 32'd1 >= n) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

endpackage

// File: rtl/picorv32_rr_pick.sv
// Combinational winner selection: round robin from ptr_i, or lowest index when fixed_i is set.
module picorv32_rr_pick
    import picorv32_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int IDW       = 1
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDW-1:0]       ptr_i,
    input  logic                 fixed_i,
    output logic                 any_o,
    output logic [IDW-1:0]       idx_o
);

    logic [IDW:0] cand;

    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        cand  = '0;
        // Walk from lowest to highest priority so the best hit is the last one written.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (fixed_i) begin
                cand = (IDW+1)'(k);
            end else begin
                cand = {1'b0, ptr_i} + (IDW+1)'(k);
                if (cand >= (IDW+1)'(NUM_PORTS)) begin
                    cand = cand - (IDW+1)'(NUM_PORTS);
                end
            end
            if (req_i[cand[IDW-1:0]]) begin
                idx_o = cand[IDW-1:0];
            end
        end
    end

endmodule

// File: rtl/picorv32_mem_arbiter.sv
// Shares one picorv32 native memory port among NUM_PORTS requesters, one transaction at a time,
// with an optional watchdog that releases a requester stuck on a silent slave.
//   state | meaning
//   IDLE  | no transaction; arbitrate among valid requesters
//   BUSY  | request presented on m_mem_*, waiting for m_mem_ready
//   DRAIN | requester already aborted by watchdog; swallow the late m_mem_ready
module picorv32_mem_arbiter
    import picorv32_arb_pkg::*;
#(
    parameter int          NUM_PORTS      = 2,
    parameter logic        FIXED_PRIORITY = 1'b0,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd0,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hdead_beef
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NUM_PORTS-1:0]          s_mem_valid_i,
    input  logic [NUM_PORTS-1:0]          s_mem_instr_i,
    input  logic [32*NUM_PORTS-1:0]       s_mem_addr_i,
    input  logic [32*NUM_PORTS-1:0]       s_mem_wdata_i,
    input  logic [4*NUM_PORTS-1:0]        s_mem_wstrb_i,
    output logic [NUM_PORTS-1:0]          s_mem_ready_o,
    output logic [32*NUM_PORTS-1:0]       s_mem_rdata_o,
    output logic                          m_mem_valid_o,
    output logic                          m_mem_instr_o,
    output logic [31:0]                   m_mem_addr_o,
    output logic [31:0]                   m_mem_wdata_o,
    output logic [3:0]                    m_mem_wstrb_o,
    input  logic                          m_mem_ready_i,
    input  logic [31:0]                   m_mem_rdata_i,
    output logic [$clog2(NUM_PORTS)-1:0]  grant_id_o,
    output logic                          busy_o,
    output logic                          timeout_flag_o
);

    localparam int IDW = $clog2(NUM_PORTS);

    arb_state_t     state_q;
    logic [IDW-1:0] rr_ptr_q;
    logic [IDW-1:0] grant_q;
    logic           m_valid_q;
    logic           m_instr_q;
    logic [31:0]    m_addr_q;
    logic [31:0]    m_wdata_q;
    logic [3:0]     m_wstrb_q;
    logic [31:0]    wd_cnt_q;
    logic [31:0]    wd_cnt_d;
    logic           timeout_q;

    logic           pick_any;
    logic [IDW-1:0] pick_idx;
    logic           wd_fire;
    logic [IDW-1:0] rr_after_grant;

    picorv32_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDW       (IDW)
    ) u_pick (
        .req_i   (s_mem_valid_i),
        .ptr_i   (rr_ptr_q),
        .fixed_i (FIXED_PRIORITY),
        .any_o   (pick_any),
        .idx_o   (pick_idx)
    );

    // A same-cycle m_mem_ready beats the watchdog.
    assign wd_fire = (TIMEOUT_CYCLES != 32'd0) && (state_q == BUSY) && !m_mem_ready_i
                     && (wd_cnt_q == TIMEOUT_CYCLES - 32'd1);
    assign wd_cnt_d       = wd_cnt_q + 32'd1;
    assign rr_after_grant = IDW'(rr_next(PTR_W'(grant_q), NUM_PORTS));

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            m_valid_q <= 1'b0;
            m_instr_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_wstrb_q <= '0;
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        state_q   <= BUSY;
                        grant_q   <= pick_idx;
                        m_valid_q <= 1'b1;
                        m_instr_q <= s_mem_instr_i[pick_idx];
                        m_addr_q  <= s_mem_addr_i[32*pick_idx +: 32];
                        m_wdata_q <= s_mem_wdata_i[32*pick_idx +: 32];
                        m_wstrb_q <= s_mem_wstrb_i[4*pick_idx +: 4];
                        wd_cnt_q  <= '0;
                    end
                end
                BUSY: begin
                    if (m_mem_ready_i) begin
                        state_q   <= IDLE;
                        m_valid_q <= 1'b0;
                        rr_ptr_q  <= rr_after_grant;
                    end else if (wd_fire) begin
                        state_q   <= DRAIN;
                        timeout_q <= 1'b1;
                    end else begin
                        wd_cnt_q  <= wd_cnt_d;
                    end
                end
                DRAIN: begin
                    if (m_mem_ready_i) begin
                        state_q   <= IDLE;
                        m_valid_q <= 1'b0;
                        rr_ptr_q  <= rr_after_grant;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        s_mem_ready_o = '0;
        s_mem_rdata_o = '0;
        if (!reset_i && (state_q == BUSY) && (m_mem_ready_i || wd_fire)) begin
            s_mem_ready_o[grant_q]            = 1'b1;
            s_mem_rdata_o[32*grant_q +: 32]   = m_mem_ready_i ? m_mem_rdata_i : TIMEOUT_RDATA;
        end
    end

    assign m_mem_valid_o  = m_valid_q;
    assign m_mem_instr_o  = m_instr_q;
    assign m_mem_addr_o   = m_addr_q;
    assign m_mem_wdata_o  = m_wdata_q;
    assign m_mem_wstrb_o  = m_wstrb_q;
    assign grant_id_o     = grant_q;
    assign busy_o         = (state_q != IDLE);
    assign timeout_flag_o = timeout_q;

endmodule

// File: tb/tb_picorv32_mem_arbiter.sv
// Bench for picorv32_mem_arbiter: a round-robin/watchdog instance and a fixed-priority instance,
// each compared every cycle against a transaction-level reference model.
module tb_picorv32_mem_arbiter;

    localparam int N  = 2;
    localparam int ND = 2;
    localparam logic [31:0] TO_DATA = 32'hdead_beef;

    logic clk = 1'b0;
    logic rst;

    logic [N-1:0]    s_valid [ND];
    logic [N-1:0]    s_instr [ND];
    logic [N-1:0]    s_ready [ND];
    logic [32*N-1:0] s_addr  [ND];
    logic [32*N-1:0] s_wdata [ND];
    logic [32*N-1:0] s_rdata [ND];
    logic [4*N-1:0]  s_wstrb [ND];
    logic            m_valid [ND];
    logic            m_instr [ND];
    logic            m_ready [ND];
    logic [31:0]     m_addr  [ND];
    logic [31:0]     m_wdata [ND];
    logic [31:0]     m_rdata [ND];
    logic [3:0]      m_wstrb [ND];
    logic [0:0]      grant   [ND];
    logic            busy    [ND];
    logic            tflag   [ND];

    always #5 clk = ~clk;

    picorv32_mem_arbiter #(
        .NUM_PORTS(N), .FIXED_PRIORITY(1'b0), .TIMEOUT_CYCLES(32'd8), .TIMEOUT_RDATA(TO_DATA)
    ) dut_rr (
        .clk_i(clk), .reset_i(rst),
        .s_mem_valid_i(s_valid[0]), .s_mem_instr_i(s_instr[0]), .s_mem_addr_i(s_addr[0]),
        .s_mem_wdata_i(s_wdata[0]), .s_mem_wstrb_i(s_wstrb[0]), .s_mem_ready_o(s_ready[0]),
        .s_mem_rdata_o(s_rdata[0]), .m_mem_valid_o(m_valid[0]), .m_mem_instr_o(m_instr[0]),
        .m_mem_addr_o(m_addr[0]), .m_mem_wdata_o(m_wdata[0]), .m_mem_wstrb_o(m_wstrb[0]),
        .m_mem_ready_i(m_ready[0]), .m_mem_rdata_i(m_rdata[0]), .grant_id_o(grant[0]),
        .busy_o(busy[0]), .timeout_flag_o(tflag[0])
    );

    picorv32_mem_arbiter #(
        .NUM_PORTS(N), .FIXED_PRIORITY(1'b1), .TIMEOUT_CYCLES(32'd0), .TIMEOUT_RDATA(TO_DATA)
    ) dut_fx (
        .clk_i(clk), .reset_i(rst),
        .s_mem_valid_i(s_valid[1]), .s_mem_instr_i(s_instr[1]), .s_mem_addr_i(s_addr[1]),
        .s_mem_wdata_i(s_wdata[1]), .s_mem_wstrb_i(s_wstrb[1]), .s_mem_ready_o(s_ready[1]),
        .s_mem_rdata_o(s_rdata[1]), .m_mem_valid_o(m_valid[1]), .m_mem_instr_o(m_instr[1]),
        .m_mem_addr_o(m_addr[1]), .m_mem_wdata_o(m_wdata[1]), .m_mem_wstrb_o(m_wstrb[1]),
        .m_mem_ready_i(m_ready[1]), .m_mem_rdata_i(m_rdata[1]), .grant_id_o(grant[1]),
        .busy_o(busy[1]), .timeout_flag_o(tflag[1])
    );

    // Reference model: who owns the port, how long it has waited, whether it was already aborted.
    int          tmo [ND];
    bit          fix [ND];
    int          owner [ND];
    int          age [ND];
    int          ptr [ND];
    int          scnt [ND];
    int          lat [ND];
    bit          aborted [ND];
    bit          flag [ND];
    logic [0:0]  lgrant [ND];
    logic [31:0] e_addr [ND];
    logic [31:0] e_wdata [ND];
    logic [3:0]  e_wstrb [ND];
    logic        e_instr [ND];
    logic [N-1:0] last_er [ND];
    logic [31:0] last_rd [ND];
    int          served [ND][$];
    int          served_t [ND][$];
    bit          rnd_lat = 1'b0;
    bit          use_fix_rdata = 1'b0;
    logic [31:0] fix_rdata = '0;
    bit          chk_en = 1'b0;
    int          cyc = 0;
    int          nchk = 0;
    int          npass = 0;
    int          nfail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_slave(input int d);
        m_ready[d] = (owner[d] >= 0) && (scnt[d] == lat[d]);
        m_rdata[d] = use_fix_rdata ? fix_rdata : $urandom;
    endtask

    task automatic check(input int d);
        logic [N-1:0]    er;
        logic [32*N-1:0] erd;
        logic [32*N-1:0] msk;
        bit              fire;
        er   = '0;
        erd  = '0;
        msk  = '1;
        fire = (owner[d] >= 0) && !aborted[d] && (m_ready[d] || (tmo[d] != 0 && age[d] == tmo[d] - 1));
        if (fire && !rst) begin
            er[owner[d]] = 1'b1;
            erd[32*owner[d] +: 32] = m_ready[d] ? m_rdata[d] : TO_DATA;
        end else if (!fire) begin
            msk[32*lgrant[d] +: 32] = '0;
        end
        last_er[d] = er;
        if (!chk_en) return;
        chk($sformatf("s_ready[%0d]", d), 64'(s_ready[d]), 64'(er));
        chk($sformatf("s_rdata[%0d]", d), 64'(s_rdata[d] & msk), 64'(erd));
        chk($sformatf("m_valid[%0d]", d), 64'(m_valid[d]), 64'(owner[d] >= 0));
        chk($sformatf("busy[%0d]", d), 64'(busy[d]), 64'(owner[d] >= 0));
        chk($sformatf("grant[%0d]", d), 64'(grant[d]), 64'(lgrant[d]));
        chk($sformatf("m_addr_wdata[%0d]", d), {m_addr[d], m_wdata[d]}, {e_addr[d], e_wdata[d]});
        chk($sformatf("m_wstrb_instr_tflag[%0d]", d), 64'({m_wstrb[d], m_instr[d], tflag[d]}),
            64'({e_wstrb[d], e_instr[d], flag[d]}));
        for (int i = 0; i < N; i++) begin
            if (s_ready[d][i]) begin
                served[d].push_back(i);
                served_t[d].push_back(cyc);
                last_rd[d] = s_rdata[d][32*i +: 32];
            end
        end
    endtask

    task automatic advance(input int d);
        int w;
        int c;
        if (rst) begin
            owner[d] = -1; ptr[d] = 0; flag[d] = 1'b0; lgrant[d] = '0; aborted[d] = 1'b0;
            age[d] = 0; scnt[d] = 0;
            e_addr[d] = '0; e_wdata[d] = '0; e_wstrb[d] = '0; e_instr[d] = 1'b0;
            return;
        end
        if (owner[d] < 0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                c = fix[d] ? k : (ptr[d] + k) % N;
                if (w < 0 && s_valid[d][c]) w = c;
            end
            if (w >= 0) begin
                owner[d] = w; lgrant[d] = 1'(w); age[d] = 0; scnt[d] = 0; aborted[d] = 1'b0;
                e_addr[d]  = s_addr[d][32*w +: 32];
                e_wdata[d] = s_wdata[d][32*w +: 32];
                e_wstrb[d] = s_wstrb[d][4*w +: 4];
                e_instr[d] = s_instr[d][w];
                if (rnd_lat) lat[d] = ($urandom_range(0, 7) == 0) ? 12 : int'($urandom_range(0, 3));
            end
        end else begin
            if (m_ready[d]) begin
                ptr[d] = (owner[d] + 1) % N;
                owner[d] = -1;
            end else if (!aborted[d] && tmo[d] != 0 && age[d] == tmo[d] - 1) begin
                aborted[d] = 1'b1;
                flag[d] = 1'b1;
            end else begin
                age[d]++;
            end
            scnt[d]++;
        end
    endtask

    task automatic step();
        for (int d = 0; d < ND; d++) drive_slave(d);
        @(negedge clk);
        for (int d = 0; d < ND; d++) check(d);
        cyc++;
        @(posedge clk);
        for (int d = 0; d < ND; d++) advance(d);
        #1;
    endtask

    task automatic req_all(input int i, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] ws, input logic ins);
        for (int d = 0; d < ND; d++) begin
            s_valid[d][i] = 1'b1;
            s_addr[d][32*i +: 32]  = a;
            s_wdata[d][32*i +: 32] = wd;
            s_wstrb[d][4*i +: 4]   = ws;
            s_instr[d][i] = ins;
        end
    endtask

    task automatic rand_req(input int d, input int i);
        s_valid[d][i] = 1'b1;
        s_addr[d][32*i +: 32]  = $urandom & 32'hffff_fffc;
        s_wdata[d][32*i +: 32] = $urandom;
        s_wstrb[d][4*i +: 4]   = $urandom_range(0, 1) ? 4'($urandom) : 4'd0;
        s_instr[d][i] = 1'($urandom);
    endtask

    task automatic drop_served();
        for (int d = 0; d < ND; d++) s_valid[d] = s_valid[d] & ~last_er[d];
    endtask

    task automatic clear_served();
        for (int d = 0; d < ND; d++) begin
            served[d].delete();
            served_t[d].delete();
        end
    endtask

    task automatic set_lat(input int l);
        rnd_lat = 1'b0;
        for (int d = 0; d < ND; d++) lat[d] = l;
    endtask

    function automatic int served_at(input int d, input int k);
        return (k < served[d].size()) ? served[d][k] : -1;
    endfunction

    initial begin
        int t0;
        tmo[0] = 8; tmo[1] = 0; fix[0] = 1'b0; fix[1] = 1'b1;
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            s_valid[d] = '0; s_instr[d] = '0; s_addr[d] = '0; s_wdata[d] = '0; s_wstrb[d] = '0;
            m_ready[d] = 1'b0; m_rdata[d] = '0; last_er[d] = '0; last_rd[d] = '0;
        end
        set_lat(0);
        repeat (2) @(posedge clk);
        for (int d = 0; d < ND; d++) advance(d);
        #1;
        chk_en = 1'b1;
        step();
        rst = 1'b0;

        // single read, slave answers after 2 wait cycles
        clear_served();
        set_lat(2);
        use_fix_rdata = 1'b1; fix_rdata = 32'h1234_5678;
        req_all(0, 32'h100, 32'h0, 4'h0, 1'b0);
        step();
        chk("t1_mvalid_after_1cycle", 64'(m_valid[0]), 64'd1);
        repeat (3) step();
        drop_served();
        step();
        chk("t1_ready_count", 64'(served[0].size()), 64'd1);
        chk("t1_rdata", 64'(last_rd[0]), 64'h1234_5678);
        use_fix_rdata = 1'b0;

        // both ports hold valid, zero-wait slave: RR alternates, fixed sticks to port 0
        rst = 1'b1; step(); rst = 1'b0;
        clear_served();
        set_lat(0);
        req_all(0, 32'h200, 32'h0, 4'h0, 1'b1);
        req_all(1, 32'h300, 32'h0, 4'h0, 1'b0);
        repeat (8) step();
        chk("t2_rr_count", 64'(served[0].size()), 64'd4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_rr_grant%0d", k), 64'(served_at(0, k)), 64'(k % 2));
            chk($sformatf("t3_fix_grant%0d", k), 64'(served_at(1, k)), 64'd0);
        end
        if (served_t[0].size() >= 4) begin
            chk("t2_port0_period", 64'(served_t[0][2] - served_t[0][0]), 64'd4);
            chk("t2_port1_period", 64'(served_t[0][3] - served_t[0][1]), 64'd4);
        end else begin
            chk("t2_period_samples", 64'(served_t[0].size()), 64'd4);
        end
        for (int d = 0; d < ND; d++) s_valid[d][0] = 1'b0;
        clear_served();
        repeat (4) step();
        chk("t3_fix_port1_after_drop", 64'(served_at(1, 0)), 64'd1);
        for (int d = 0; d < ND; d++) s_valid[d] = '0;

        // write with partial strobes
        clear_served();
        set_lat(1);
        req_all(1, 32'h400, 32'haabb_ccdd, 4'b0110, 1'b0);
        step();
        chk("t4_wstrb", 64'(m_wstrb[0]), 64'b0110);
        chk("t4_wdata", 64'(m_wdata[0]), 64'haabb_ccdd);
        repeat (2) step();
        drop_served();
        repeat (2) step();
        chk("t4_single_pulse", 64'(served[0].size()), 64'd1);
        chk("t4_pulse_port", 64'(served_at(0, 0)), 64'd1);

        // watchdog: slave silent for 20 BUSY cycles
        clear_served();
        set_lat(20);
        req_all(0, 32'h500, 32'h0, 4'h0, 1'b0);
        req_all(1, 32'h600, 32'h0, 4'h0, 1'b0);
        t0 = cyc;
        repeat (23) step();
        chk("t5_abort_count", 64'(served[0].size()), 64'd1);
        chk("t5_abort_port", 64'(served_at(0, 0)), 64'd0);
        if (served_t[0].size() > 0) chk("t5_abort_cycle", 64'(served_t[0][0] - t0), 64'd8);
        chk("t5_abort_rdata", 64'(last_rd[0]), 64'(TO_DATA));
        chk("t5_timeout_flag", 64'(tflag[0]), 64'd1);
        chk("t5_no_wd_when_disabled", 64'(tflag[1]), 64'd0);
        chk("t5_next_grant", 64'(grant[0]), 64'd1);
        chk("t5_next_addr", 64'(m_addr[0]), 64'h600);

        // reset while BUSY with the slave answering in the same cycle
        clear_served();
        for (int d = 0; d < ND; d++) begin
            lat[d] = scnt[d];
            s_valid[d] = '0;
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_no_pulse", 64'(served[0].size() + served[1].size()), 64'd0);
        chk("t6_mvalid", 64'(m_valid[0]), 64'd0);
        chk("t6_busy", 64'(busy[0]), 64'd0);
        chk("t6_tflag", 64'(tflag[0]), 64'd0);
        chk("t6_fields", {m_addr[0], 28'd0, m_wstrb[0]}, 64'd0);
        set_lat(0);
        req_all(0, 32'h700, 32'h0, 4'h0, 1'b0);
        req_all(1, 32'h800, 32'h0, 4'h0, 1'b0);
        step();
        chk("t6_rr_ptr_reset", 64'(grant[0]), 64'd0);
        repeat (2) step();
        for (int d = 0; d < ND; d++) s_valid[d] = '0;
        repeat (3) step();

        // randomized traffic with occasional long slaves and resets
        rnd_lat = 1'b1;
        for (int n = 0; n < 800; n++) begin
            for (int d = 0; d < ND; d++) begin
                for (int i = 0; i < N; i++) begin
                    if (s_valid[d][i]) begin
                        if (last_er[d][i]) begin
                            if ($urandom_range(0, 1) == 1) rand_req(d, i);
                            else s_valid[d][i] = 1'b0;
                        end
                    end else if ($urandom_range(0, 3) == 0) begin
                        rand_req(d, i);
                    end
                end
            end
            rst = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
